// File: rtl/writeback_if.sv
// Writeback port bundle: instruction handshake in, load data in,
// register-file write port and timeout flag out.
//
// Handshake: the upstream stage holds in_valid and its payload stable until
// in_ready is seen high; an instruction is taken on the rising edge where
// in_valid && in_ready are both 1. While in_ready is low the payload is ignored.
// mem_rvalid/mem_rdata are sampled only while a load is being completed.
interface writeback_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    opcode;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] ra;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_timeout;

  modport master (
    output in_valid, opcode, rs_addr, rt_addr, alu_out, ra, mem_rvalid, mem_rdata,
    input  in_ready, wr_en, wr_addr, wr_data, mem_timeout
  );

  modport slave (
    input  in_valid, opcode, rs_addr, rt_addr, alu_out, ra, mem_rvalid, mem_rdata,
    output in_ready, wr_en, wr_addr, wr_data, mem_timeout
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: decodes the instruction class, drives a registered
// register-file write one cycle after acceptance, and waits (bounded) for
// load data when it is not available at acceptance time.
module writeback_unit #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int LINK_REG    = 2**AW-1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  writeback_if.slave   bus,
  output logic         fsm_state
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);
  // Last count value before the wait limit is reached.
  localparam logic [7:0]    CNT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          tmo_q, tmo_d;
  logic          rdy_q;

  logic [1:0] op_class;
  logic [3:0] op_funct;
  logic       is_alu, is_link, is_load, xfer;

  assign op_class = bus.opcode[5:4];
  assign op_funct = bus.opcode[3:0];
  assign is_alu   = (op_class == 2'b00) && (op_funct != 4'b0010) && (op_funct != 4'b0011);
  assign is_link  = (op_class == 2'b11) && (op_funct == 4'b1001);
  assign is_load  = (op_class == 2'b01) && (op_funct == 4'b0000);

  // rdy_q keeps in_ready low during reset and raises it on the first clean edge.
  assign bus.in_ready    = rdy_q && (state_q == IDLE);
  assign xfer            = bus.in_valid && bus.in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.mem_timeout = tmo_q;
  assign fsm_state       = (state_q == WAIT_MEM);

  // State and output registers; reset abandons any outstanding load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tmo_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_addr_q <= ld_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
      rdy_q     <= 1'b1;
    end
  end

  // Next state and next write; the write port returns to zero whenever no write is due.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_addr_d = ld_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (is_alu) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.rs_addr;
            wr_data_d = bus.alu_out;
          end else if (is_link) begin
            wr_en_d   = 1'b1;
            wr_addr_d = LINK_ADDR;
            wr_data_d = bus.ra;
          end else if (is_load) begin
            if (bus.mem_rvalid) begin
              wr_en_d   = 1'b1;
              wr_addr_d = bus.rt_addr;
              wr_data_d = bus.mem_rdata;
            end else begin
              ld_addr_d = bus.rt_addr;
              cnt_d     = '0;
              state_d   = WAIT_MEM;
            end
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the limit cycle still wins over the timeout.
        if (bus.mem_rvalid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ld_addr_q;
          wr_data_d = bus.mem_rdata;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, checked
// against a cycle-level behavioural model of the writeback rules.
module tb_writeback_unit;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TMO = 15;

  logic clk;
  logic rst_n;
  logic fsm_state;
  int   checks;
  int   errors;

  writeback_if #(.DW(DW), .AW(AW)) bus ();

  writeback_unit #(.DW(DW), .AW(AW), .LINK_REG(31), .MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic          m_wait;
  int            m_waited;
  logic [AW-1:0] m_pend;
  logic          m_tmo;
  logic          m_ready;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic void model_step();
    m_en = 1'b0; m_addr = '0; m_data = '0;
    if (!rst_n) begin
      m_wait = 1'b0; m_waited = 0; m_tmo = 1'b0; m_ready = 1'b0; m_pend = '0;
      return;
    end
    if (!m_wait) begin
      if (bus.in_valid && m_ready) begin
        if (bus.opcode[5:4] == 2'b00 && bus.opcode[3:0] != 4'd2 && bus.opcode[3:0] != 4'd3) begin
          m_en = 1'b1; m_addr = bus.rs_addr; m_data = bus.alu_out;
        end else if (bus.opcode == 6'b111001) begin
          m_en = 1'b1; m_addr = 5'd31; m_data = bus.ra;
        end else if (bus.opcode == 6'b010000) begin
          if (bus.mem_rvalid) begin
            m_en = 1'b1; m_addr = bus.rt_addr; m_data = bus.mem_rdata;
          end else begin
            m_wait = 1'b1; m_waited = 0; m_pend = bus.rt_addr;
          end
        end
      end
    end else begin
      m_waited = m_waited + 1;
      if (bus.mem_rvalid) begin
        m_en = 1'b1; m_addr = m_pend; m_data = bus.mem_rdata; m_wait = 1'b0;
      end else if (m_waited == TMO) begin
        m_tmo = 1'b1; m_wait = 1'b0;
      end
    end
    m_ready = !m_wait;
  endfunction

  function automatic logic [39:0] obs();
    return {bus.wr_en, bus.wr_addr, bus.wr_data, bus.in_ready, bus.mem_timeout};
  endfunction

  function automatic logic [39:0] exp_v();
    return {m_en, m_addr, m_data, m_ready, m_tmo};
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] alu, input logic [31:0] r,
                       input logic rv, input logic [31:0] rd);
    @(negedge clk);
    bus.in_valid = v;  bus.opcode = op; bus.rs_addr = rs; bus.rt_addr = rt;
    bus.alu_out = alu; bus.ra = r;     bus.mem_rvalid = rv; bus.mem_rdata = rd;
  endtask

  task automatic idle_in(input logic rv, input logic [31:0] rd);
    drive(1'b0, 6'h3f, $urandom_range(31), $urandom_range(31), $urandom, $urandom, rv, rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    idle_in(1'b0, 32'h0);
    tick();
    tick();
    checks++;
    if (obs() !== 40'h0) begin
      errors++; $display("FAIL reset_values obs=%h exp=%h", obs(), 40'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || obs() !== exp_v()) begin
      errors++; $display("FAIL reset_release obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_alu();
    drive(1'b1, 6'b000000, 5'd3, 5'd9, 32'h0000_00AA, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hAA || obs() !== exp_v()) begin
      errors++; $display("FAIL alu_write obs=%h exp=%h", obs(), exp_v());
    end
    idle_in(1'b0, 32'h0);
    tick();
    checks++;
    if (bus.wr_en !== 1'b0 || obs() !== exp_v()) begin
      errors++; $display("FAIL alu_pulse_end obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_back_to_back_nowrite();
    drive(1'b1, 6'b000010, 5'd4, 5'd5, 32'h1234, 32'h5678, 1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 38'h0 || obs() !== exp_v()) begin
      errors++; $display("FAIL nowrite_000010 obs=%h exp=%h", obs(), exp_v());
    end
    drive(1'b1, 6'b110000, 5'd6, 5'd7, 32'h9999, 32'h8888, 1'b0, 32'h0);
    tick();
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 38'h0 || obs() !== exp_v()) begin
      errors++; $display("FAIL nowrite_110000 obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_link();
    drive(1'b1, 6'b111001, 5'd2, 5'd2, 32'hFFFF, 32'h0000_1004, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd31 || bus.wr_data !== 32'h1004 || obs() !== exp_v()) begin
      errors++; $display("FAIL link_write obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_load_wait();
    drive(1'b1, 6'b010000, 5'd1, 5'd7, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        drive(1'b1, 6'b000000, 5'd8, 5'd8, 32'h77, 32'h0, 1'b0, 32'h0);
        tick();
      end
      checks++;
      if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || obs() !== exp_v()) begin
        errors++; $display("FAIL load_wait_stall cyc=%0d obs=%h exp=%h", i, obs(), exp_v());
      end
    end
    drive(1'b0, 6'h3f, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_data !== 32'hDEAD_BEEF ||
        bus.in_ready !== 1'b1 || obs() !== exp_v()) begin
      errors++; $display("FAIL load_wait_data obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_load_immediate();
    drive(1'b1, 6'b010000, 5'd0, 5'd12, 32'h0, 32'h0, 1'b1, 32'hCAFE_0001);
    tick();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd12 || bus.wr_data !== 32'hCAFE_0001 ||
        bus.in_ready !== 1'b1 || obs() !== exp_v()) begin
      errors++; $display("FAIL load_immediate obs=%h exp=%h", obs(), exp_v());
    end
    // Stray load data while idle must not write.
    idle_in(1'b1, 32'h5555_AAAA);
    tick();
    checks++;
    if (bus.wr_en !== 1'b0 || obs() !== exp_v()) begin
      errors++; $display("FAIL idle_rvalid_ignored obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_data_wins_at_limit();
    drive(1'b1, 6'b010000, 5'd0, 5'd20, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 1; i < TMO; i++) begin
      idle_in(1'b0, 32'h0);
      tick();
    end
    idle_in(1'b1, 32'h0BAD_F00D);
    tick();
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd20 || bus.wr_data !== 32'h0BAD_F00D ||
        bus.mem_timeout !== 1'b0 || obs() !== exp_v()) begin
      errors++; $display("FAIL data_wins_limit obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_timeout();
    drive(1'b1, 6'b010000, 5'd0, 5'd9, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 1; i <= TMO; i++) begin
      idle_in(1'b0, 32'h0);
      tick();
      checks++;
      if (bus.wr_en !== 1'b0 || bus.mem_timeout !== (i == TMO) || bus.in_ready !== (i == TMO) ||
          obs() !== exp_v()) begin
        errors++; $display("FAIL timeout_wait cyc=%0d obs=%h exp=%h", i, obs(), exp_v());
      end
    end
    drive(1'b1, 6'b000000, 5'd1, 5'd1, 32'h11, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.mem_timeout !== 1'b1 || bus.wr_en !== 1'b1 || obs() !== exp_v()) begin
      errors++; $display("FAIL timeout_sticky obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1'b1, 6'b010000, 5'd0, 5'd15, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_in(1'b0, 32'h0);
    tick();
    @(negedge clk); rst_n = 1'b0;
    tick();
    checks++;
    if (obs() !== 40'h0) begin
      errors++; $display("FAIL reset_in_wait obs=%h exp=%h", obs(), 40'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_2468;
    tick();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.mem_timeout !== 1'b0 || obs() !== exp_v()) begin
      errors++; $display("FAIL reset_abandons_load obs=%h exp=%h", obs(), exp_v());
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops[0] = 6'b000000; ops[1] = 6'b000010; ops[2] = 6'b000011; ops[3] = 6'b001111;
    ops[4] = 6'b111001; ops[5] = 6'b110000; ops[6] = 6'b010000; ops[7] = 6'b010001;
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(9) < 8) ? ops[$urandom_range(7)] : 6'($urandom);
      drive($urandom_range(3) != 0, op, 5'($urandom), 5'($urandom), $urandom, $urandom,
            $urandom_range(9) < 2, $urandom);
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL random cyc=%0d op=%b obs=%h exp=%h", i, op, obs(), exp_v());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_wait = 1'b0; m_waited = 0; m_pend = '0; m_tmo = 1'b0; m_ready = 1'b0;
    m_en = 1'b0; m_addr = '0; m_data = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.opcode = '0; bus.rs_addr = '0; bus.rt_addr = '0;
    bus.alu_out = '0; bus.ra = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_alu();
    test_back_to_back_nowrite();
    test_link();
    test_load_wait();
    test_load_immediate();
    test_data_wins_at_limit();
    test_timeout();
    test_reset_in_wait();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DW, default 32, data width of register-file write data.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter LINK_REG, default 2**AW-1, register written by jump-and-link.
REQ-004 Parameter MEM_TIMEOUT, default 15, maximum cycles waited for load data (1..255).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 in_valid  in  1  instruction presented for writeback.
REQ-008 in_ready  out  1  unit can accept an instruction this cycle.
REQ-009 opcode  in  6  class = opcode[5:4], funct = opcode[3:0].
REQ-010 rs_addr, rt_addr  in  AW each  source/destination fields.
REQ-011 alu_out, ra  in  DW each  ALU result, return address.
REQ-012 mem_rvalid  in  1  load data valid; mem_rdata  in  DW  load data.
REQ-013 wr_en  out  1 (registered), wr_addr  out  AW (registered), wr_data  out  DW (registered): register-file write port.
REQ-014 mem_timeout  out  1  sticky flag: load data never arrived.

Function
REQ-015 Transfer occurs when in_valid && in_ready; otherwise inputs are ignored.
REQ-016 Decode: class 00 with funct not 0010/0011 -> write alu_out to rs_addr; class 11 with funct 1001 -> write ra to LINK_REG; class 01 with funct 0000 -> load, write mem_rdata to rt_addr; all other encodings -> no write.
REQ-017 Non-writing encodings (including class 00 funct 0010/0011) drive wr_en=0, wr_addr=0, wr_data=0 the cycle after transfer; no previous value is held.
REQ-018 ALU/link writes: wr_en/wr_addr/wr_data valid exactly 1 cycle after transfer, for 1 cycle.
REQ-019 States: IDLE, WAIT_MEM; in_ready=1 only in IDLE.
REQ-020 Load transfer with mem_rvalid=1 in the same cycle: write issued next cycle, state stays IDLE.
REQ-021 Load transfer with mem_rvalid=0: latch rt_addr, go WAIT_MEM, clear wait counter to 0.
REQ-022 WAIT_MEM: counter increments each cycle; on mem_rvalid=1, issue write of mem_rdata to latched rt_addr next cycle and return to IDLE.
REQ-023 WAIT_MEM: if counter reaches MEM_TIMEOUT without mem_rvalid, set mem_timeout, issue no write, return to IDLE.
REQ-024 mem_rvalid in the same cycle the counter reaches MEM_TIMEOUT: data wins, write issued, mem_timeout unchanged.
REQ-025 mem_rvalid while IDLE and no load transferring: ignored.
REQ-026 wr_en pulses are single-cycle; wr_en=0 on every cycle with no pending write.
REQ-027 wr_addr/wr_data are exactly AW/DW bits; no truncation or extension occurs internally.
REQ-028 mem_timeout cleared only by reset.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, counter=0, wr_en=0, wr_addr=0, wr_data=0, mem_timeout=0, in_ready=0.
REQ-030 First edge with rst_n=1: in_ready=1.
REQ-031 Reset asserted during WAIT_MEM abandons the load; no write issued afterwards.

Verification
REQ-032 opcode 000000, rs_addr=3, alu_out=0x0000_00AA, in_valid=1 -> next cycle wr_en=1, wr_addr=3, wr_data=0xAA; following cycle wr_en=0.
REQ-033 opcode 000010 then 110000 back-to-back -> wr_en=0, wr_addr=0, wr_data=0 for both result cycles.
REQ-034 opcode 111001, ra=0x0000_1004 -> wr_en=1, wr_addr=31, wr_data=0x1004.
REQ-035 opcode 010000, rt_addr=7, mem_rvalid low 3 cycles then high with mem_rdata=0xDEAD_BEEF -> in_ready=0 for 4 cycles, then write 0xDEADBEEF to 7, in_ready=1.
REQ-036 Load with mem_rvalid never asserted, MEM_TIMEOUT=15 -> mem_timeout=1 after 15 wait cycles, no wr_en, in_ready returns 1; stays set until reset.
REQ-037 Load stalled in WAIT_MEM, rst_n=0 for 1 cycle, then mem_rvalid=1 -> no write, all outputs at reset values.
